mul_unit: RTL and testbench



---
 rtl/mul_unit.sv | 141 ++++++++++++++
 tb/tb_mul_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier feeding the register file write port; one multiplier bit per cycle, N cycles.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_unit #(
  parameter int N  = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic [AW-1:0] wa,
  output logic          we
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  localparam logic [AW-1:0] XZR  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_dst;
  logic [N-1:0]  r_result;
  logic [AW-1:0] r_wa;
  logic          r_done;
  logic          r_we;

  logic [N-1:0]  w_acc_next;
  logic [N-1:0]  w_mcand_next;
  logic [N-1:0]  w_mplr_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_last;
  logic          w_accept;
  logic          w_finish;

  // One partial-product step; the sum wraps modulo 2^N by construction.
  always_comb begin
    w_acc_next   = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    w_mcand_next = r_mcand << 1;
    w_mplr_next  = r_mplr >> 1;
    w_cnt_next   = r_cnt + CW'(1);
`ifdef MUL_EARLY_EXIT_EN
    w_last       = (w_cnt_next == LAST) || (w_mplr_next == '0);
`else
    w_last       = (w_cnt_next == LAST);
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Accepting here gives back-to-back operation with no idle bubble.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_cnt    <= '0;
      r_dst    <= '0;
      r_result <= '0;
      r_wa     <= '0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_we   <= w_finish && (r_dst != XZR);
      if (w_accept) begin
        r_acc   <= '0;
        r_mcand <= a;
        r_mplr  <= b;
        r_cnt   <= '0;
        r_dst   <= dst;
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_next;
        r_mcand <= w_mcand_next;
        r_mplr  <= w_mplr_next;
        r_cnt   <= w_cnt_next;
      end
      // result/wa hold until the next completion.
      if (w_finish) begin
        r_result <= w_acc_next;
        r_wa     <= r_dst;
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = r_done;
  assign we     = r_we;
  assign result = r_result;
  assign wa     = r_wa;

endmodule

// File: tb/tb_mul_unit.sv
// Randomized self-checking bench for mul_unit against a plain-arithmetic product and latency model.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [4:0]  dst = '0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  wa;
  logic        we;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] rf_mdl [32];

  mul_unit #(.N(64), .AW(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .dst    (dst),
    .busy   (busy),
    .done   (done),
    .result (result),
    .wa     (wa),
    .we     (we)
  );

  always #5 clk = ~clk;

  // Register file sink: captures the write port mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) rf_mdl[wa] = result;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Iterations needed: full width, or up to the top set multiplier bit with early exit.
  function automatic int exp_lat(input logic [63:0] op_b);
    int k;
`ifdef MUL_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < 64; i++) if (op_b[i]) k = i + 1;
`else
    k = 64;
`endif
    return k;
  endfunction

  // Called #1 after an edge; the next edge is the accepting edge E0.
  task automatic start_op(input logic [63:0] op_a, input logic [63:0] op_b, input logic [4:0] op_dst);
    a = op_a; b = op_b; dst = op_dst; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    dst = 5'($urandom);
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_done", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] op_a, input logic [63:0] op_b,
                           input logic [4:0] op_dst, input int pulse_at);
    int cyc;
    int k;
    logic [63:0] prod;
    cyc = 0;
    k = exp_lat(op_b);
    prod = op_a * op_b;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc + 1 == pulse_at) begin
        start = 1'b1; a = 64'd9; b = 64'd9; dst = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && k > 1) check({tag, "_busy"}, 64'(busy), 64'd1);
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'(k));
    check({tag, "_result"}, result, prod);
    check({tag, "_wa"}, 64'(wa), 64'(op_dst));
    check({tag, "_we"}, 64'(we), (op_dst == 5'd31) ? 64'd0 : 64'd1);
  endtask

  task automatic check_idle(input string tag, input logic [63:0] exp_res, input logic [4:0] exp_wa);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 64'(done), 64'd0);
    check({tag, "_we_fall"}, 64'(we), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_res_hold"}, result, exp_res);
    check({tag, "_wa_hold"}, 64'(wa), 64'(exp_wa));
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [4:0]  rd;
    int          pulse;
    int          stray;

    for (int i = 0; i < 32; i++) rf_mdl[i] = '0;

    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wa", 64'(wa), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    start_op(64'd69, 64'd3, 5'd6);
    wait_done("basic", 64'd69, 64'd3, 5'd6, 0);
    check_idle("basic", 64'd207, 5'd6);
    check("rf_x6", rf_mdl[6], 64'd207);

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7);
    wait_done("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 0);
    check("wrap_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
    check_idle("wrap", 64'hFFFF_FFFF_FFFF_FFFE, 5'd7);

    start_op(64'd75, 64'd1, 5'd31);
    wait_done("xzr", 64'd75, 64'd1, 5'd31, 0);
    check("xzr_done", 64'(done), 64'd1);
    check_idle("xzr", 64'd75, 5'd31);
    check("rf_x31", rf_mdl[31], 64'd0);

    // A start pulse while RUN must be dropped.
    pulse = (exp_lat(64'd5) > 10) ? 10 : exp_lat(64'd5) - 1;
    start_op(64'd5, 64'd5, 5'd1);
    wait_done("ignore", 64'd5, 64'd5, 5'd1, pulse);
    check_idle("ignore", 64'd25, 5'd1);

    start_op(64'd5, 64'd5, 5'd1);
    wait_done("b2b_first", 64'd5, 64'd5, 5'd1, 0);
    start_op(64'd9, 64'd9, 5'd2);
    wait_done("b2b_second", 64'd9, 64'd9, 5'd2, 0);
    check_idle("b2b", 64'd81, 5'd2);

    start_op(64'd7, 64'd5, 5'd10);
    wait_done("early", 64'd7, 64'd5, 5'd10, 0);
    check_idle("early", 64'd35, 5'd10);
    start_op(64'd3, 64'd0, 5'd11);
    wait_done("zero_b", 64'd3, 64'd0, 5'd11, 0);
    check_idle("zero_b", 64'd0, 5'd11);

    // Asynchronous reset mid-operation discards the multiply.
    rf_mdl[4] = '0;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, 5'd4);
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_we", 64'(we), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_wa", 64'(wa), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stray = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
    end
    check("midrst_quiet", 64'(stray), 64'd0);
    check("midrst_rf_x4", rf_mdl[4], 64'd0);
    start_op(64'd12, 64'd13, 5'd4);
    wait_done("after_rst", 64'd12, 64'd13, 5'd4, 0);
    check_idle("after_rst", 64'd156, 5'd4);

    repeat (20) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      rd = 5'($urandom);
      start_op(ra, rb, rd);
      wait_done("rnd", ra, rb, rd, 0);
      if ($urandom_range(0, 1) == 1) check_idle("rnd", ra * rb, rd);
    end
    check_idle("final", ra * rb, rd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
